// File: rtl/scroll_display_ctrl_pkg.sv
// Shared types and width helpers for the scrolling display controller.
package scroll_display_ctrl_pkg;

  localparam int CHAR_W = 4;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } scan_state_e;

  // Bits needed to hold 0..n-1, never narrower than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/scroll_display_ctrl_btn_debounce.sv
// Button front end: 2-FF synchroniser, consecutive-sample debounce, one pulse per accepted press.
module scroll_display_ctrl_btn_debounce
  import scroll_display_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);

  localparam int             CW       = width_of(DEBOUNCE_CYC);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          meta_q;
  logic          sync_q;
  logic          level_q;
  logic          press_q;
  logic [CW-1:0] cnt_q;

  // cnt_q counts consecutive samples that disagree with the accepted level.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q  <= 1'b0;
      sync_q  <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      meta_q  <= btn_i;
      sync_q  <= meta_q;
      press_q <= 1'b0;
      if (sync_q == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_q   <= '0;
        level_q <= sync_q;
        press_q <= sync_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling message display sequencer: button-driven scroll offset, digit scan with
// anti-ghost blanking, and optional automatic scrolling at a fixed frame rate.
module scroll_display_ctrl
  import scroll_display_ctrl_pkg::*;
#(
  parameter int  NUM_DIGITS   = 4,
  parameter int  MSG_LEN      = 8,
  parameter int  DEBOUNCE_CYC = 16,
  parameter int  SCAN_CYC     = 1000,
  parameter int  BLANK_CYC    = 50,
  parameter int  AUTO_FRAMES  = 64,
  localparam int AW           = width_of(MSG_LEN)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_left,
  input  logic                  btn_right,
  input  logic                  auto_en,
  input  logic [CHAR_W-1:0]     char_data,
  output logic [AW-1:0]         char_addr,
  output logic [CHAR_W-1:0]     char_out,
  output logic [NUM_DIGITS-1:0] an_n,
  output logic [AW-1:0]         offset,
  output logic                  frame_tick
);

  localparam int DW      = width_of(NUM_DIGITS);
  localparam int CW      = width_of((SCAN_CYC > BLANK_CYC) ? SCAN_CYC : BLANK_CYC);
  localparam int FW      = width_of(AUTO_FRAMES);
  localparam int SW      = AW + 1;

  localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0]         BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [CW-1:0]         SCAN_LAST  = CW'(SCAN_CYC - 1);
  localparam logic [FW-1:0]         FRAME_LAST = FW'(AUTO_FRAMES - 1);
  localparam logic [AW-1:0]         MSG_LAST   = AW'(MSG_LEN - 1);
  localparam logic [SW-1:0]         MSG_LEN_W  = SW'(MSG_LEN);
  localparam logic [NUM_DIGITS-1:0] AN_ONE     = NUM_DIGITS'(1);

  scan_state_e             state_q;
  logic [DW-1:0]           digit_q;
  logic [CW-1:0]           cnt_q;
  logic [FW-1:0]           frame_cnt_q;
  logic [NUM_DIGITS-1:0]   an_n_q;
  logic [CHAR_W-1:0]       char_out_q;
  logic                    frame_tick_q;
  logic [AW-1:0]           offset_q;
  logic [AW-1:0]           pending_q;
  logic [AW-1:0]           pending_d;

  logic                    press_left;
  logic                    press_right;
  logic                    frame_end;
  logic                    auto_step;
  logic [SW-1:0]           addr_sum;

  scroll_display_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_left),
    .press_o (press_left)
  );

  scroll_display_ctrl_btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
    .clk     (clk),
    .reset   (reset),
    .btn_i   (btn_right),
    .press_o (press_right)
  );

  // One extra bit keeps offset+digit exact before the wrap, so any MSG_LEN works.
  assign addr_sum  = SW'(offset_q) + SW'(digit_q);
  assign char_addr = (addr_sum >= MSG_LEN_W) ? AW'(addr_sum - MSG_LEN_W) : addr_sum[AW-1:0];

  assign frame_end = (state_q == ST_SHOW) && (cnt_q == SCAN_LAST) && (digit_q == DIGIT_LAST);
  assign auto_step = auto_en && frame_end && (frame_cnt_q == FRAME_LAST);

  // A button pulse in the auto-step cycle suppresses that auto step.
  always_comb begin
    pending_d = pending_q;
    if (press_right && !press_left) begin
      pending_d = (pending_q == MSG_LAST) ? '0 : pending_q + AW'(1);
    end else if (press_left && !press_right) begin
      pending_d = (pending_q == '0) ? MSG_LAST : pending_q - AW'(1);
    end else if (!press_right && !press_left && auto_step) begin
      pending_d = (pending_q == MSG_LAST) ? '0 : pending_q + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_BLANK;
      digit_q      <= '0;
      cnt_q        <= '0;
      frame_cnt_q  <= '0;
      an_n_q       <= '1;
      char_out_q   <= '0;
      frame_tick_q <= 1'b0;
      offset_q     <= '0;
      pending_q    <= '0;
    end else begin
      frame_tick_q <= 1'b0;
      pending_q    <= pending_d;
      case (state_q)
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            cnt_q      <= '0;
            state_q    <= ST_SHOW;
            char_out_q <= char_data;
            an_n_q     <= ~(AN_ONE << digit_q);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        ST_SHOW: begin
          if (cnt_q == SCAN_LAST) begin
            cnt_q   <= '0;
            state_q <= ST_BLANK;
            an_n_q  <= '1;
            if (digit_q == DIGIT_LAST) begin
              // Offset only moves here so a frame never mixes two offsets.
              digit_q      <= '0;
              offset_q     <= pending_q;
              frame_tick_q <= 1'b1;
              frame_cnt_q  <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FW'(1);
            end else begin
              digit_q <= digit_q + DW'(1);
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: state_q <= ST_BLANK;
      endcase
    end
  end

  assign char_out   = char_out_q;
  assign an_n       = an_n_q;
  assign offset     = offset_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Scoreboard bench for scroll_display_ctrl with small timing parameters and ROM[i]=i.
module tb_scroll_display_ctrl;

  localparam int NUM_DIGITS = 4;
  localparam int MSG_LEN    = 8;
  localparam int AW         = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            btn_left = 1'b0;
  logic            btn_right = 1'b0;
  logic            auto_en = 1'b0;
  logic [3:0]      char_data;
  logic [AW-1:0]   char_addr;
  logic [3:0]      char_out;
  logic [3:0]      an_n;
  logic [AW-1:0]   offset;
  logic            frame_tick;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic [3:0] an;
    logic [3:0] ch;
  } exp_t;
  exp_t sb[$];

  // Model state: button contribution is owned by the tests, auto steps by the monitor.
  int btn_adj = 0;
  int auto_steps = 0;
  int ntick = 0;
  int exp_off = 0;

  logic [3:0] got_an[4];
  logic [3:0] got_ch[4];

  always #5 clk = ~clk;

  assign char_data = {1'b0, char_addr};

  scroll_display_ctrl #(
    .NUM_DIGITS   (4),
    .MSG_LEN      (8),
    .DEBOUNCE_CYC (4),
    .SCAN_CYC     (3),
    .BLANK_CYC    (1),
    .AUTO_FRAMES  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_left   (btn_left),
    .btn_right  (btn_right),
    .auto_en    (auto_en),
    .char_data  (char_data),
    .char_addr  (char_addr),
    .char_out   (char_out),
    .an_n       (an_n),
    .offset     (offset),
    .frame_tick (frame_tick)
  );

  // Offset model: commit pending at every frame tick, auto step on every second frame.
  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      ntick      = 0;
      auto_steps = 0;
      exp_off    = 0;
    end else if (frame_tick === 1'b1) begin
      ntick++;
      exp_off = (((btn_adj + auto_steps) % MSG_LEN) + MSG_LEN) % MSG_LEN;
      if (auto_en && (ntick % 2 == 0)) auto_steps++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_frame_tick(output int n, output bit ok);
    n  = 0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      tick();
      n++;
      if (frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Records an_n/char_out at the start of each lit digit; called from a frame-tick cycle.
  task automatic capture_frame(output bit ok);
    int k;
    logic [3:0] prev;
    k    = 0;
    prev = an_n;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (an_n !== 4'hF && prev === 4'hF) begin
        got_an[k] = an_n;
        got_ch[k] = char_out;
        k++;
      end
      prev = an_n;
      if (k == 4) break;
    end
    ok = (k == 4);
  endtask

  task automatic push_frame(input int off);
    exp_t e;
    logic [3:0] one;
    one = 4'b0001;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      e.an = ~(one << d);
      e.ch = 4'((off + d) % MSG_LEN);
      sb.push_back(e);
    end
  endtask

  task automatic press(input bit left, input bit right, input int hi, input int lo);
    btn_left  = left;
    btn_right = right;
    repeat (hi) tick();
    btn_left  = 1'b0;
    btn_right = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic test_reset();
    int n;
    bit ok;
    reset = 1'b1;
    repeat (3) tick();
    vectors++;
    if (an_n !== 4'hF || char_out !== 4'h0 || frame_tick !== 1'b0 || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL reset_state: got an_n=%b char_out=%0h tick=%b offset=%0d want 1111/0/0/0",
               an_n, char_out, frame_tick, offset);
    end
    reset = 1'b0;
    vectors++;
    if (an_n !== 4'hF) begin
      miscompares++;
      $display("FAIL first_blank: got an_n=%b want 1111", an_n);
    end
    tick();
    vectors++;
    if (an_n !== 4'b1110 || char_out !== 4'h0) begin
      miscompares++;
      $display("FAIL digit0_lit: got an_n=%b char_out=%0h want 1110/0", an_n, char_out);
    end
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || n + 1 != 16) begin
      miscompares++;
      $display("FAIL first_frame_len: got %0d cycles (ok=%0d) want 16", n + 1, ok);
    end
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || n != 16) begin
      miscompares++;
      $display("FAIL frame_period: got %0d cycles (ok=%0d) want 16", n, ok);
    end
    tick();
    vectors++;
    if (frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL tick_width: got frame_tick=%b want 0", frame_tick);
    end
  endtask

  task automatic test_scan();
    int n;
    bit ok;
    exp_t e;
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off)) begin
      miscompares++;
      $display("FAIL scan_offset: got %0d (ok=%0d) want %0d", offset, ok, exp_off);
    end
    push_frame(exp_off);
    capture_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL scan_capture: got incomplete frame want 4 lit digits");
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      e = sb.pop_front();
      vectors++;
      if (got_an[d] !== e.an || got_ch[d] !== e.ch) begin
        miscompares++;
        $display("FAIL scan_digit%0d: got an_n=%b char=%0h want %b/%0h", d, got_an[d], got_ch[d], e.an, e.ch);
      end
    end
  endtask

  task automatic test_right_press();
    int n;
    bit ok;
    exp_t e;
    wait_frame_tick(n, ok);
    press(1'b0, 1'b1, 10, 0);
    btn_adj++;
    vectors++;
    if (offset !== AW'(exp_off) || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL right_hold_offset: got %0d want %0d", offset, exp_off);
    end
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off) || offset !== 3'd1) begin
      miscompares++;
      $display("FAIL right_commit: got %0d (ok=%0d) want 1", offset, ok);
    end
    push_frame(1);
    capture_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL right_capture: got incomplete frame want 4 lit digits");
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      e = sb.pop_front();
      vectors++;
      if (got_an[d] !== e.an || got_ch[d] !== e.ch) begin
        miscompares++;
        $display("FAIL right_digit%0d: got an_n=%b char=%0h want %b/%0h", d, got_an[d], got_ch[d], e.an, e.ch);
      end
    end
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== 3'd1) begin
      miscompares++;
      $display("FAIL right_single_pulse: got %0d (ok=%0d) want 1", offset, ok);
    end
  endtask

  task automatic test_left_wrap();
    int n;
    bit ok;
    exp_t e;
    wait_frame_tick(n, ok);
    press(1'b1, 1'b0, 5, 5);
    btn_adj--;
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off) || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL left_to_zero: got %0d (ok=%0d) want 0", offset, ok);
    end
    press(1'b1, 1'b0, 5, 5);
    btn_adj--;
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off) || offset !== 3'd7) begin
      miscompares++;
      $display("FAIL left_wrap: got %0d (ok=%0d) want 7", offset, ok);
    end
    push_frame(7);
    capture_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL left_capture: got incomplete frame want 4 lit digits");
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      e = sb.pop_front();
      vectors++;
      if (got_an[d] !== e.an || got_ch[d] !== e.ch) begin
        miscompares++;
        $display("FAIL wrap_digit%0d: got an_n=%b char=%0h want %b/%0h", d, got_an[d], got_ch[d], e.an, e.ch);
      end
    end
    press(1'b0, 1'b1, 5, 5);
    btn_adj++;
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off) || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL right_wrap: got %0d (ok=%0d) want 0", offset, ok);
    end
  endtask

  task automatic test_bounce();
    int n;
    bit ok;
    wait_frame_tick(n, ok);
    for (int i = 0; i < 30; i++) begin
      btn_right = ((i / 2) % 2 == 0);
      tick();
    end
    btn_right = 1'b0;
    wait_frame_tick(n, ok);
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== AW'(exp_off)) begin
      miscompares++;
      $display("FAIL bounce_offset: got %0d (ok=%0d) want %0d", offset, ok, exp_off);
    end
  endtask

  task automatic test_both_then_auto();
    int n;
    bit ok;
    logic [AW-1:0] start;
    logic [AW-1:0] delta;
    wait_frame_tick(n, ok);
    press(1'b1, 1'b1, 10, 5);
    for (int f = 0; f < 2; f++) begin
      wait_frame_tick(n, ok);
      vectors++;
      if (!ok || offset !== AW'(exp_off)) begin
        miscompares++;
        $display("FAIL both_offset%0d: got %0d (ok=%0d) want %0d", f, offset, ok, exp_off);
      end
    end
    auto_en = 1'b1;
    wait_frame_tick(n, ok);
    start = offset;
    for (int f = 0; f < 4; f++) begin
      wait_frame_tick(n, ok);
      vectors++;
      if (!ok || offset !== AW'(exp_off)) begin
        miscompares++;
        $display("FAIL auto_offset%0d: got %0d (ok=%0d) want %0d", f, offset, ok, exp_off);
      end
    end
    delta = offset - start;
    vectors++;
    if (delta !== 3'd2) begin
      miscompares++;
      $display("FAIL auto_rate: got +%0d over 4 frames want +2", delta);
    end
    auto_en = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    bit ok;
    exp_t e;
    logic [3:0] want_ch;
    wait_frame_tick(n, ok);
    want_ch = 4'((exp_off + 3) % MSG_LEN);
    press(1'b0, 1'b1, 4, 4);
    press(1'b0, 1'b1, 4, 0);
    tick();
    vectors++;
    if (an_n !== 4'b0111 || char_out !== want_ch) begin
      miscompares++;
      $display("FAIL mid_show: got an_n=%b char=%0h want 0111/%0h", an_n, char_out, want_ch);
    end
    reset = 1'b1;
    tick();
    btn_adj = 0;
    vectors++;
    if (an_n !== 4'hF || char_out !== 4'h0 || frame_tick !== 1'b0 || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: got an_n=%b char=%0h tick=%b offset=%0d want 1111/0/0/0",
               an_n, char_out, frame_tick, offset);
    end
    repeat (2) tick();
    reset = 1'b0;
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== 3'd0 || offset !== AW'(exp_off)) begin
      miscompares++;
      $display("FAIL post_reset_offset: got %0d (ok=%0d) want 0", offset, ok);
    end
    push_frame(0);
    capture_frame(ok);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL post_reset_capture: got incomplete frame want 4 lit digits");
    end
    for (int d = 0; d < NUM_DIGITS; d++) begin
      e = sb.pop_front();
      vectors++;
      if (got_an[d] !== e.an || got_ch[d] !== e.ch) begin
        miscompares++;
        $display("FAIL post_reset_digit%0d: got an_n=%b char=%0h want %b/%0h", d, got_an[d], got_ch[d], e.an, e.ch);
      end
    end
    wait_frame_tick(n, ok);
    vectors++;
    if (!ok || offset !== 3'd0) begin
      miscompares++;
      $display("FAIL presses_dropped: got %0d (ok=%0d) want 0", offset, ok);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_right_press();
    test_left_wrap();
    test_bounce();
    test_both_then_auto();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want summary before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
